// File: rtl/bash_pkg.sv
// Shared types and constants for the bash terminal line agent.
// The byte strings are packed MSB-first: character 0 sits in the top byte.
package bash_pkg;

   localparam int BUFFER_LEN = 128;
   localparam int HELP_LEN   = 20;
   localparam int NF_LEN     = 17;

   localparam logic [7:0] CHAR_NUL   = 8'h00;
   localparam logic [7:0] CHAR_SPACE = 8'h20;

   localparam logic [31:0] KW_ECHO = "echo";
   localparam logic [31:0] KW_HELP = "help";
   localparam logic [31:0] KW_READ = "read";

   localparam logic [8*HELP_LEN-1:0] HELP_STR = "cmds: echo help read";
   localparam logic [8*NF_LEN-1:0]   NF_STR   = "command not found";

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_GAP,
      S_DRAIN,
      S_DECODE,
      S_RESP,
      S_RESP_GAP,
      S_REQ,
      S_WAIT_LINE,
      S_SOLVE
   } state_e;

   typedef enum logic [1:0] {
      SRC_BUF,
      SRC_HELP,
      SRC_NF
   } src_e;

   // Clamp the terminal's 13-bit line length to what the buffer can hold.
   function automatic logic [7:0] clamp_len(input logic [12:0] len);
      if (len > 13'(BUFFER_LEN)) begin
         return 8'(BUFFER_LEN);
      end
      return len[7:0];
   endfunction

endpackage

// File: rtl/bash_resp_rom.sv
// Fixed response strings (help / not-found) indexed by character position.
// Positions past the string end read back as the line terminator.
module bash_resp_rom
   import bash_pkg::*;
(
   input  src_e       sel_i,
   input  logic [7:0] idx_i,
   output logic [7:0] char_o
);

   logic [8*HELP_LEN-1:0] help_sh;
   logic [8*NF_LEN-1:0]   nf_sh;

   // Shift the wanted character into the top byte instead of indexing variably.
   assign help_sh = HELP_STR << {idx_i, 3'b000};
   assign nf_sh   = NF_STR << {idx_i, 3'b000};

   always_comb begin
      char_o = CHAR_NUL;
      unique case (sel_i)
         SRC_HELP: begin
            if (idx_i < 8'(HELP_LEN)) begin
               char_o = help_sh[8*HELP_LEN-1 -: 8];
            end
         end
         SRC_NF: begin
            if (idx_i < 8'(NF_LEN)) begin
               char_o = nf_sh[8*NF_LEN-1 -: 8];
            end
         end
         default: char_o = CHAR_NUL;
      endcase
   end

endmodule

// File: rtl/bash_line_agent.sv
// Command-side peer of the bash terminal: captures a line, decodes the
// built-in commands, streams the response and completes the solve handshake.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | wait for a command line from the terminal
// FETCH      | store one character, pulse cmd_next
// GAP        | let the terminal's read index settle
// DRAIN      | wait for cmd_ready to drop so the line is not re-captured
// DECODE     | pick the response source
// RESP       | present response characters until the terminator is taken
// RESP_GAP   | one idle cycle after the terminator
// REQ        | ask the terminal for one more user line
// WAIT_LINE  | like IDLE, but the captured line is echoed back
// SOLVE      | hold solved_req until the terminal acknowledges
module bash_line_agent
   import bash_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_ready,
   input  logic [12:0] cmd_len,
   input  logic [7:0]  cmd_char,
   output logic        cmd_next,
   output logic        resp_ready,
   output logic [7:0]  resp_char,
   input  logic        resp_next,
   output logic        solved_req,
   input  logic        solved_ack,
   output logic        line_req,
   input  logic        line_ack
);

   state_e     state_q, state_d;
   logic [7:0] len_q, len_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] ptr_q, ptr_d;
   logic [7:0] end_q, end_d;
   src_e       src_q, src_d;
   logic       echo_line_q, echo_line_d;

   logic [7:0]  buf_q [BUFFER_LEN];
   logic [7:0]  len_in;
   logic [7:0]  rom_char;
   logic [7:0]  buf_char;
   logic [7:0]  cur_char;
   logic [31:0] kw;

   assign len_in   = clamp_len(cmd_len);
   assign kw       = {buf_q[0], buf_q[1], buf_q[2], buf_q[3]};
   assign buf_char = (ptr_q < end_q) ? buf_q[ptr_q[6:0]] : CHAR_NUL;
   assign cur_char = (src_q == SRC_BUF) ? buf_char : rom_char;

   bash_resp_rom u_rom (
      .sel_i  (src_q),
      .idx_i  (ptr_q),
      .char_o (rom_char)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         ptr_q       <= '0;
         end_q       <= '0;
         src_q       <= SRC_BUF;
         echo_line_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         ptr_q       <= ptr_d;
         end_q       <= end_d;
         src_q       <= src_d;
         echo_line_q <= echo_line_d;
      end
   end

   // Line storage carries no reset: only indices below len_q are ever read.
   always_ff @(posedge clk) begin
      if (state_q == S_FETCH) begin
         buf_q[cnt_q[6:0]] <= cmd_char;
      end
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      ptr_d       = ptr_q;
      end_d       = end_q;
      src_d       = src_q;
      echo_line_d = echo_line_q;
      cmd_next    = 1'b0;
      resp_ready  = 1'b0;
      resp_char   = CHAR_NUL;
      solved_req  = 1'b0;
      line_req    = 1'b0;

      unique case (state_q)
         S_IDLE, S_WAIT_LINE: begin
            if (cmd_ready) begin
               len_d       = len_in;
               cnt_d       = '0;
               echo_line_d = (state_q == S_WAIT_LINE);
               state_d     = (len_in == 8'd0) ? S_DRAIN : S_FETCH;
            end
         end
         S_FETCH: begin
            cmd_next = 1'b1;
            cnt_d    = cnt_q + 8'd1;
            state_d  = S_GAP;
         end
         S_GAP: begin
            state_d = (cnt_q < len_q) ? S_FETCH : S_DRAIN;
         end
         S_DRAIN: begin
            if (!cmd_ready) begin
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            echo_line_d = 1'b0;
            ptr_d       = '0;
            end_d       = '0;
            src_d       = SRC_BUF;
            // len_q >= 4 keeps stale bytes of an earlier line from matching.
            if (echo_line_q) begin
               end_d   = len_q;
               state_d = S_RESP;
            end else if (len_q == 8'd0) begin
               state_d = S_SOLVE;
            end else if (len_q >= 8'd4 && kw == KW_ECHO &&
                         (len_q == 8'd4 || buf_q[4] == CHAR_SPACE)) begin
               ptr_d   = (len_q <= 8'd5) ? len_q : 8'd5;
               end_d   = len_q;
               state_d = S_RESP;
            end else if (len_q == 8'd4 && kw == KW_HELP) begin
               src_d   = SRC_HELP;
               state_d = S_RESP;
            end else if (len_q == 8'd4 && kw == KW_READ) begin
               state_d = S_REQ;
            end else begin
               src_d   = SRC_NF;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            resp_ready = 1'b1;
            resp_char  = cur_char;
            if (resp_next) begin
               if (cur_char == CHAR_NUL) begin
                  state_d = S_RESP_GAP;
               end else begin
                  ptr_d = ptr_q + 8'd1;
               end
            end
         end
         S_RESP_GAP: begin
            state_d = S_SOLVE;
         end
         S_REQ: begin
            line_req = 1'b1;
            if (line_ack) begin
               state_d = S_WAIT_LINE;
            end
         end
         S_SOLVE: begin
            solved_req = 1'b1;
            if (solved_ack) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_bash_line_agent.sv
// Terminal model around bash_line_agent: feeds command lines, consumes the
// response stream against a queue of expected characters and acks handshakes.
module tb_bash_line_agent;

   logic        clk;
   logic        rst_n;
   logic        cmd_ready;
   logic [12:0] cmd_len;
   logic [7:0]  cmd_char;
   logic        cmd_next;
   logic        resp_ready;
   logic [7:0]  resp_char;
   logic        resp_next;
   logic        solved_req;
   logic        solved_ack;
   logic        line_req;
   logic        line_ack;

   bash_line_agent dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_ready  (cmd_ready),
      .cmd_len    (cmd_len),
      .cmd_char   (cmd_char),
      .cmd_next   (cmd_next),
      .resp_ready (resp_ready),
      .resp_char  (resp_char),
      .resp_next  (resp_next),
      .solved_req (solved_req),
      .solved_ack (solved_ack),
      .line_req   (line_req),
      .line_ack   (line_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   localparam string HELP_S = "cmds: echo help read";
   localparam string NF_S   = "command not found";

   logic [7:0] exp_q [$];
   logic [7:0] line_b [256];
   int  line_seq  = 0;
   int  seen_seq  = 0;
   int  term_idx  = 0;
   bit  nx_pend   = 1'b0;
   int  pulses    = 0;
   int  last_cyc  = 0;
   int  cyc       = 0;
   int  gap_bad   = 0;
   int  rsp_idx   = 0;
   int  stall_at  = -1;
   int  stalled_at = -1;
   bit  stall_bad = 1'b0;

   typedef struct {
      string line;
      int    len;
      int    pulses;
      string exp;
      bit    term;
   } vec_t;
   vec_t vecs [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push_resp(input string s, input bit term);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      if (term) exp_q.push_back(8'h00);
   endtask

   // Terminal read side: advance the line index one cycle after each cmd_next.
   initial begin
      cmd_char = 8'h00;
      forever begin
         @(negedge clk);
         cyc++;
         if (seen_seq != line_seq) begin
            seen_seq = line_seq;
            term_idx = 0;
            nx_pend  = 1'b0;
            pulses   = 0;
         end else if (nx_pend) begin
            term_idx++;
            nx_pend = 1'b0;
         end
         if (rst_n && cmd_next) begin
            if (pulses > 0 && cyc - last_cyc != 2) gap_bad++;
            last_cyc = cyc;
            pulses++;
            nx_pend = 1'b1;
         end
         cmd_char = (term_idx < 256) ? line_b[term_idx] : 8'h00;
      end
   end

   // Terminal write side: consume resp_char, optionally stalling once.
   initial begin
      logic [7:0] hold;
      logic [7:0] e;
      resp_next = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n || !resp_ready) begin
            resp_next = 1'b0;
         end else begin
            if (rsp_idx == stall_at && stalled_at != stall_at) begin
               stalled_at = stall_at;
               resp_next  = 1'b0;
               hold       = resp_char;
               stall_bad  = 1'b0;
               repeat (4000) begin
                  @(negedge clk);
                  if (resp_char !== hold || resp_ready !== 1'b1) stall_bad = 1'b1;
               end
            end
            if (exp_q.size() == 0) begin
               tests++;
               failed++;
               $display("FAIL resp_extra: got char %0h, expected no response", resp_char);
            end else begin
               e = exp_q.pop_front();
               check("resp_char", 32'(resp_char), 32'(e));
            end
            rsp_idx++;
            resp_next = 1'b1;
         end
      end
   end

   task automatic send_line(input string s, input int len, input int exp_pulses, input string name);
      int n;
      for (int i = 0; i < 256; i++) line_b[i] = (i < s.len()) ? s[i] : 8'h00;
      line_seq++;
      cmd_len   = 13'(len);
      cmd_ready = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (pulses < exp_pulses && n < 2000);
      if (n >= 2000) check({name, "_fetch_timeout"}, 32'(pulses), 32'(exp_pulses));
      cmd_ready = 1'b0;
      repeat (4) tick();
      check({name, "_pulses"}, 32'(pulses), 32'(exp_pulses));
   endtask

   task automatic finish_solve(input string name);
      int n;
      n = 0;
      while (solved_req !== 1'b1 && n < 6000) begin
         tick();
         n++;
      end
      check({name, "_solved_req"}, 32'(solved_req), 32'd1);
      check({name, "_resp_left"}, 32'(exp_q.size()), 32'd0);
      repeat (3) tick();
      check({name, "_solved_hold"}, {31'd0, solved_req}, 32'd1);
      solved_ack = 1'b1;
      tick();
      check({name, "_solved_drop"}, {31'd0, solved_req}, 32'd0);
      solved_ack = 1'b0;
      repeat (2) tick();
   endtask

   task automatic add_vec(input string line, input int len, input int p, input string exp, input bit term);
      vec_t v;
      v.line = line; v.len = len; v.pulses = p; v.exp = exp; v.term = term;
      vecs.push_back(v);
   endtask

   initial begin
      string long_s;
      int n;
      int base;
      rst_n = 1'b0; cmd_ready = 1'b0; cmd_len = '0;
      solved_ack = 1'b0; line_ack = 1'b0;
      for (int i = 0; i < 256; i++) line_b[i] = 8'h00;

      long_s = "";
      for (int i = 0; i < 200; i++) long_s = {long_s, "x"};

      add_vec("echo hi",  7,   7,   "hi",  1'b1);
      add_vec("",         0,   0,   "",    1'b0);
      add_vec("echo",     4,   4,   "",    1'b1);
      add_vec("echox",    5,   5,   NF_S,  1'b1);
      add_vec("help",     4,   4,   HELP_S, 1'b1);
      add_vec("echo a b", 8,   8,   "a b", 1'b1);
      add_vec("ec",       2,   2,   NF_S,  1'b1);
      add_vec("Echo hi",  7,   7,   NF_S,  1'b1);
      add_vec("echo ",    5,   5,   "",    1'b1);
      add_vec("echo  x",  7,   7,   " x",  1'b1);
      add_vec(long_s,     200, 128, NF_S,  1'b1);
      add_vec("helpme",   6,   6,   NF_S,  1'b1);

      repeat (3) tick();
      check("reset_outputs", {20'd0, cmd_next, resp_ready, solved_req, line_req, resp_char}, 32'd0);
      rst_n = 1'b1;
      repeat (2) tick();

      for (int v = 0; v < vecs.size(); v++) begin
         push_resp(vecs[v].exp, vecs[v].term);
         send_line(vecs[v].line, vecs[v].len, vecs[v].pulses, $sformatf("vec%0d", v));
         finish_solve($sformatf("vec%0d", v));
      end

      // Long terminal stall in the middle of a response.
      push_resp(NF_S, 1'b1);
      stall_at = rsp_idx + 5;
      send_line("foo", 3, 3, "stall");
      finish_solve("stall");
      check("stall_taken", 32'(stalled_at), 32'(stall_at));
      check("stall_stable", {31'd0, stall_bad}, 32'd0);

      // read: request one user line, then echo it.
      push_resp("abc", 1'b1);
      send_line("read", 4, 4, "read");
      n = 0;
      while (line_req !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      repeat (3) tick();
      check("read_line_req", {30'd0, line_req, resp_ready}, 32'b10);
      line_ack = 1'b1;
      tick();
      check("read_line_drop", {31'd0, line_req}, 32'd0);
      line_ack = 1'b0;
      send_line("abc", 3, 3, "read_abc");
      finish_solve("read");

      // Reset while the response is streaming.
      push_resp(NF_S, 1'b1);
      base = rsp_idx;
      send_line("foo", 3, 3, "rst");
      n = 0;
      while (rsp_idx < base + 3 && n < 200) begin
         tick();
         n++;
      end
      #1;
      check("rst_in_resp", {31'd0, resp_ready}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_outputs", {20'd0, cmd_next, resp_ready, solved_req, line_req, resp_char}, 32'd0);
      repeat (3) tick();
      exp_q.delete();
      rst_n = 1'b1;
      repeat (2) tick();
      push_resp(HELP_S, 1'b1);
      send_line("help", 4, 4, "post_rst");
      finish_solve("post_rst");

      check("cmd_next_spacing", 32'(gap_bad), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/bash_line_agent.md
Name: bash_line_agent

Overview:
Command-side peer of the bash video-memory terminal. It reads each line the terminal emits after Enter and decodes a small built-in command set. It writes response lines back to the terminal for display, then completes the solved handshake so the terminal shows a new prompt. It also drives the require-line handshake so a running command can read one more user line.

Parameters:
BUFFER_LEN, 128, maximum stored command characters; matches the terminal's clamp on line length.
HELP_LEN, 20, length of the fixed help string "cmds: echo help read".
NF_LEN, 17, length of the fixed string "command not found".

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_ready  in  1  terminal line available (terminal out_newASCII_ready)
cmd_len  in  13  line length, valid while cmd_ready (terminal out_lineLen)
cmd_char  in  8  current line character (terminal lineOut)
cmd_next  out  1  one-cycle pulse: character consumed (terminal lineOut_nextASCII)
resp_ready  out  1  response character valid (terminal in_newASCII_ready)
resp_char  out  8  response character; 8'h00 terminates a line (terminal lineIn)
resp_next  in  1  terminal consumed resp_char (terminal lineIn_nextASCII)
solved_req  out  1  command finished (terminal in_solved)
solved_ack  in  1  terminal acknowledged solve (terminal out_solved)
line_req  out  1  request one user input line (terminal in_require_line)
line_ack  in  1  terminal accepted the request (terminal out_require_line)

Behaviour:
- Reset/interface: clk is the single clock; rst_n is asynchronous, active-low. While rst_n=0, all outputs are 0, state=IDLE and all counters are 0. Reset mid-transfer abandons the transfer immediately with no flush.
- States: IDLE, FETCH, GAP, DRAIN, DECODE, RESP, RESP_GAP, REQ, WAIT_LINE, SOLVE.
- IDLE:
  - When cmd_ready=1: latch len=min(cmd_len,BUFFER_LEN) and set cnt=0.
  - Go to DRAIN if len=0, else FETCH.
  - resp_ready stays 0.
- FETCH:
  - Store cmd_char into buf[cnt], cnt++, drive cmd_next=1 for exactly one cycle, go to GAP.
  - GAP deasserts cmd_next and waits one cycle so the terminal's index update is visible.
  - Then go to FETCH if cnt<len, else DRAIN.
  - Cadence: one character per 2 cycles.
  - cmd_next is never pulsed once cnt=len.
- DRAIN: wait for cmd_ready=0, then go to DECODE. Prevents re-capturing the same line.
- DECODE (1 cycle) selects the response source; comparison is case-sensitive:
  - Came from WAIT_LINE: echo buf[0..len-1].
  - len=0: no output, go to SOLVE.
  - buf[0..3]="echo" and (len=4 or buf[4]=' '): echo buf[5..len-1]; if len<=5, emit the terminator only.
  - len=4 and "help": help ROM.
  - len=4 and "read": go to REQ.
  - Otherwise: not-found ROM.
- RESP:
  - Assert resp_ready=1 with resp_char = current source character; after the last character, resp_char=8'h00.
  - On resp_next=1 (sampled at the edge), advance the pointer and hold resp_ready.
  - When the acknowledged character was 8'h00: drop resp_ready, spend one cycle in RESP_GAP, then go to SOLVE.
  - resp_char must be stable from assertion until resp_next.
- REQ:
  - Hold resp_ready=0 and line_req=1 until line_ack=1.
  - Then drop line_req in the same edge and go to WAIT_LINE.
- WAIT_LINE: behaves like IDLE; the captured line is flagged for echo.
- SOLVE:
  - Hold solved_req=1 until solved_ack=1 is sampled; drop it on that edge, then go to IDLE.
  - solved_req must never be high for a cycle after solved_ack has been seen, otherwise the terminal double-solves.
- Terminal stalls (screen scroll, thousands of cycles) are tolerated by waiting indefinitely on every handshake; there are no timeouts.
- cmd_len > BUFFER_LEN: the terminal already clamps; the agent clamps again defensively.

Decomposition:
- Shared package bash_pkg:
  - state enum;
  - BUFFER_LEN, CHAR_NUL=8'h00, CHAR_SPACE=8'h20;
  - command keyword constants;
  - help and not-found string constants.
- One natural sub-module: bash_resp_rom. It is combinational and maps {sel, index} to a character, returning 8'h00 past the string end.

Test Plan:
- Line "echo hi" (cmd_len=7):
  - 7 cmd_next pulses spaced 2 cycles apart;
  - resp_char sequence 'h','i',00;
  - then solved_req held until solved_ack, cleared the same edge.
- cmd_len=0: zero cmd_next pulses, no resp_ready, solved_req asserted directly.
- Line "foo": 17 characters "command not found" then 00; the terminal model inserts a 4000-cycle stall before one resp_next, and resp_char must stay constant throughout.
- Line "read":
  - line_req=1 with resp_ready=0 until line_ack;
  - the model then sends "abc";
  - agent emits 'a','b','c',00, then solves.
- Line "echo" (len=4): single 00 response. Line "echox": not-found response.
- rst_n pulsed low during RESP at character index 3: all outputs 0 within the same cycle; a fresh "help" line then returns "cmds: echo help read",00.
